// File: rtl/test_seq_pkg.sv
// Shared types and constants for the riscv-tests run controller.
package test_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_PASS    = 2'b01;
  localparam logic [1:0] RES_FAIL    = 2'b10;
  localparam logic [1:0] RES_TIMEOUT = 2'b11;

  localparam logic [31:0] DEFAULT_PASS_PC = 32'h0000_0044;

  // Verdict code reported while sitting in a given state.
  function automatic logic [1:0] result_code(input state_t s);
    case (s)
      S_PASS:    return RES_PASS;
      S_FAIL:    return RES_FAIL;
      S_TIMEOUT: return RES_TIMEOUT;
      default:   return RES_NONE;
    endcase
  endfunction

  function automatic logic is_terminal(input state_t s);
    return (s == S_PASS) || (s == S_FAIL) || (s == S_TIMEOUT);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Saturating event counter that flags when an enabled cycle sees count == limit.
module seq_watchdog #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         expired
);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Fires during the enabled cycle that would make the count reach limit+1.
  assign expired = enable && (count == limit);

endmodule

// File: rtl/test_sequencer.sv
// Run controller for one riscv-tests program: reset hold, run, grade, watchdog.
// Optional hang detection is built when TEST_SEQ_STALL_DETECT_EN is defined.
module test_sequencer
  import test_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 2,
  parameter int unsigned TIMEOUT_TICKS = 5000,
  parameter logic [31:0] PASS_PC       = DEFAULT_PASS_PC,
  parameter int unsigned STALL_LIMIT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] core_pc,
  input  logic [31:0] core_gp,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic [1:0]  result,
  output logic [31:0] cycle_count
);

  localparam int unsigned HW = $clog2(RESET_CYCLES) + 1;

  if (RESET_CYCLES == 0 || TIMEOUT_TICKS == 0 || STALL_LIMIT == 0) begin : g_param_check
    $error("test_sequencer: RESET_CYCLES, TIMEOUT_TICKS and STALL_LIMIT must be >= 1");
  end

  state_t        state;
  state_t        state_nxt;
  logic [HW-1:0] hold_cnt;
  logic          hold_last;
  logic          run_start;
  logic          in_run;
  logic          pc_match;
  logic          timeout_hit;
  logic          stall_hit;

  assign in_run    = (state == S_RUN);
  assign pc_match  = (core_pc == PASS_PC);
  assign hold_last = (hold_cnt == HW'(RESET_CYCLES - 1));
  assign run_start = (state_nxt == S_HOLD) && (state != S_HOLD);

  // Hold counter only advances in HOLD, so it is already zero on entry.
  always_ff @(posedge clk) begin
    if (!rst || (state != S_HOLD)) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  seq_watchdog #(.W(32)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (run_start),
    .enable  (in_run),
    .limit   (32'(TIMEOUT_TICKS - 1)),
    .count   (cycle_count),
    .expired (timeout_hit)
  );

`ifdef TEST_SEQ_STALL_DETECT_EN
  logic [31:0] prev_pc;
  logic [31:0] stall_cnt;
  logic        pc_same;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_pc <= '0;
    end else begin
      prev_pc <= core_pc;
    end
  end

  assign pc_same = (core_pc == prev_pc);

  // Counts consecutive RUN cycles with an unchanged PC; any change restarts it.
  seq_watchdog #(.W(32)) u_stall (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_run || !pc_same),
    .enable  (in_run && pc_same),
    .limit   (32'(STALL_LIMIT - 1)),
    .count   (stall_cnt),
    .expired (stall_hit)
  );
`else
  assign stall_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_PASS, S_FAIL, S_TIMEOUT: begin
        if (start) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (hold_last) state_nxt = S_RUN;
      end
      S_RUN: begin
        // PC match outranks stall, which outranks timeout.
        if (pc_match) begin
          state_nxt = (core_gp == 32'd1) ? S_PASS : S_FAIL;
        end else if (stall_hit) begin
          state_nxt = S_FAIL;
        end else if (timeout_hit) begin
          state_nxt = S_TIMEOUT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      core_rst <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= RES_NONE;
    end else begin
      state    <= state_nxt;
      core_rst <= (state_nxt != S_RUN);
      busy     <= (state_nxt == S_HOLD) || (state_nxt == S_RUN);
      done     <= is_terminal(state_nxt);
      result   <= result_code(state_nxt);
    end
  end

endmodule

// File: tb/tb_test_sequencer.sv
// Self-checking bench for test_sequencer: two instances share stimulus, one with a
// long watchdog and one with a short one, graded against a run-level model.
module tb_test_sequencer;

  localparam int          RC   = 2;
  localparam int          TT_A = 300;
  localparam int          TT_B = 50;
  localparam int          SL   = 8;
  localparam logic [31:0] PPC  = 32'h44;
  localparam int          TT [2] = '{TT_A, TT_B};

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] core_pc;
  logic [31:0] core_gp;
  logic [1:0]  o_rst;
  logic [1:0]  o_busy;
  logic [1:0]  o_done;
  logic [1:0]  o_result [2];
  logic [31:0] o_count [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  test_sequencer #(.RESET_CYCLES(RC), .TIMEOUT_TICKS(TT_A), .PASS_PC(PPC), .STALL_LIMIT(SL)) dut_a (
    .clk(clk), .rst(rst), .start(start), .core_pc(core_pc), .core_gp(core_gp),
    .core_rst(o_rst[0]), .busy(o_busy[0]), .done(o_done[0]),
    .result(o_result[0]), .cycle_count(o_count[0])
  );

  test_sequencer #(.RESET_CYCLES(RC), .TIMEOUT_TICKS(TT_B), .PASS_PC(PPC), .STALL_LIMIT(SL)) dut_b (
    .clk(clk), .rst(rst), .start(start), .core_pc(core_pc), .core_gp(core_gp),
    .core_rst(o_rst[1]), .busy(o_busy[1]), .done(o_done[1]),
    .result(o_result[1]), .cycle_count(o_count[1])
  );

  // Run-level model: a PC match before the watchdog runs out decides the verdict
  // from gp; otherwise the run times out after TT cycles.
  function automatic int model_end(input int match, input int tt);
    return (match >= 0 && match < tt) ? match : tt - 1;
  endfunction

  function automatic logic [1:0] model_result(input int match, input logic [31:0] gp, input int tt);
    if (match >= 0 && match < tt) return (gp == 32'd1) ? 2'b01 : 2'b10;
    return 2'b11;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_rst[i] !== 1'b1 || o_busy[i] !== 1'b0 || o_done[i] !== 1'b0 ||
          o_result[i] !== 2'b00 || o_count[i] !== 32'd0) begin
        failures++;
        $display("[TB] FAIL %s inst%0d: core_rst=%b busy=%b done=%b result=%b count=%0d, want 1 0 0 00 0",
                 name, i, o_rst[i], o_busy[i], o_done[i], o_result[i], o_count[i]);
      end
    end
  endtask

  // Start a run, then wait out the reset hold; returns with both instances in RUN cycle 0.
  task automatic begin_run(input string name);
    int n;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_rst[i] !== 1'b1 || o_busy[i] !== 1'b1 || o_done[i] !== 1'b0 ||
          o_result[i] !== 2'b00 || o_count[i] !== 32'd0) begin
        failures++;
        $display("[TB] FAIL %s start inst%0d: core_rst=%b busy=%b done=%b result=%b count=%0d, want 1 1 0 00 0",
                 name, i, o_rst[i], o_busy[i], o_done[i], o_result[i], o_count[i]);
      end
    end
    n = 0;
    while (o_rst[0] === 1'b1 && n < 10) begin
      tick;
      n++;
    end
    checks++;
    if (n != RC || o_rst !== 2'b00) begin
      failures++;
      $display("[TB] FAIL %s hold: core_rst high for %0d cycles (rst=%b), want %0d then 00", name, n, o_rst, RC);
    end
  endtask

  // One full run with a PC match at RUN cycle 'match' (-1: never) and an optional
  // start pulse at RUN cycle 'start_at' (-1: none) that must be ignored.
  task automatic do_run(input int match, input logic [31:0] gp, input int start_at, input string name);
    int          dn [2];
    int          ec [2];
    logic [1:0]  er [2];
    for (int i = 0; i < 2; i++) begin
      dn[i] = -1;
      ec[i] = model_end(match, TT[i]);
      er[i] = model_result(match, gp, TT[i]);
    end
    begin_run(name);
    for (int k = 0; k < 400 && (dn[0] < 0 || dn[1] < 0); k++) begin
      for (int i = 0; i < 2; i++) begin
        if (dn[i] < 0) begin
          checks++;
          if (o_rst[i] !== 1'b0 || o_busy[i] !== 1'b1 || o_count[i] !== 32'(k)) begin
            failures++;
            $display("[TB] FAIL %s run inst%0d cyc%0d: core_rst=%b busy=%b count=%0d, want 0 1 %0d",
                     name, i, k, o_rst[i], o_busy[i], o_count[i], k);
          end
        end
      end
      core_pc = (k == match) ? PPC : 32'h1000 + 32'(4 * k);
      core_gp = (k == match) ? gp : $urandom;
      start   = (k == start_at);
      tick;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (dn[i] < 0 && o_done[i] === 1'b1) begin
          dn[i] = k;
          checks++;
          if (k != ec[i] || o_result[i] !== er[i] || o_count[i] !== 32'(ec[i] + 1) ||
              o_rst[i] !== 1'b1 || o_busy[i] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s verdict inst%0d: done at cyc%0d result=%b count=%0d core_rst=%b busy=%b, want cyc%0d %b %0d 1 0",
                     name, i, k, o_result[i], o_count[i], o_rst[i], o_busy[i], ec[i], er[i], ec[i] + 1);
          end
        end
      end
    end
    core_pc = 32'h2000;
    tick;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dn[i] < 0 || o_done[i] !== 1'b1 || o_result[i] !== er[i] || o_count[i] !== 32'(ec[i] + 1)) begin
        failures++;
        $display("[TB] FAIL %s held inst%0d: finished=%0d done=%b result=%b count=%0d, want 1 1 %b %0d",
                 name, i, dn[i] >= 0, o_done[i], o_result[i], o_count[i], er[i], ec[i] + 1);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick;
    tick;
    check_idle("reset");
    rst = 1'b1;
    tick;
    check_idle("idle_after_reset");
  endtask

  task automatic test_pass_fail;
    do_run(100, 32'd1, -1, "pass_c100");
    do_run(100, 32'd5, -1, "fail_c100");
    do_run(0, 32'd1, -1, "pass_c0");
  endtask

  task automatic test_timeout;
    do_run(49, 32'd1, -1, "match_c49");
    do_run(49, 32'd0, -1, "fail_c49");
    do_run(50, 32'd7, -1, "match_c50");
    do_run(-1, 32'd1, -1, "never_match");
  endtask

  task automatic test_start_ignored;
    do_run(120, 32'd1, 10, "start_in_run");
  endtask

  task automatic test_reset_mid_run;
    begin_run("rst_mid_run");
    for (int k = 0; k < 6; k++) begin
      core_pc = 32'h3000 + 32'(4 * k);
      tick;
    end
    rst   = 1'b0;
    start = 1'b1;
    tick;
    check_idle("rst_mid_run");
    rst   = 1'b1;
    start = 1'b0;
    tick;
    check_idle("idle_after_mid_rst");
  endtask

  task automatic test_back_to_back;
    int m;
    for (int r = 0; r < 8; r++) begin
      m = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 320));
      do_run(m, ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom, -1, "random");
    end
  endtask

`ifdef TEST_SEQ_STALL_DETECT_EN
  // A core parked on one non-terminal PC fails after SL unchanged RUN cycles.
  task automatic test_stall;
    int dn [2];
    dn[0] = -1;
    dn[1] = -1;
    core_pc = 32'h100;
    begin_run("stall");
    for (int k = 0; k < 60 && (dn[0] < 0 || dn[1] < 0); k++) begin
      core_gp = $urandom;
      tick;
      for (int i = 0; i < 2; i++) begin
        if (dn[i] < 0 && o_done[i] === 1'b1) dn[i] = k;
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dn[i] != SL - 1 || o_result[i] !== 2'b10 || o_count[i] !== 32'(SL)) begin
        failures++;
        $display("[TB] FAIL stall inst%0d: done at cyc%0d result=%b count=%0d, want cyc%0d 10 %0d",
                 i, dn[i], o_result[i], o_count[i], SL - 1, SL);
      end
    end
  endtask
`endif

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    core_pc = 32'h0;
    core_gp = 32'h0;
    test_reset;
    test_pass_fail;
    test_timeout;
    test_start_ignored;
    test_reset_mid_run;
    test_back_to_back;
`ifdef TEST_SEQ_STALL_DETECT_EN
    test_stall;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
